// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory responder.
//   SZ_*      request size encodings (2'b11 is reserved and behaves as word)
//   state_e   load FSM states
//   is_aligned helper: natural alignment test for a size/byte-lane pair
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lane[0];
      default: ok = (lane == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port 2^ADDR_W x 32 RAM with per-byte write enables and a
// registered read port (block-RAM friendly).
//   clk_i    clock
//   en_i     access enable
//   be_i     byte write enables; all-zero with en_i=1 performs a read
//   addr_i   word address
//   wdata_i  write data, already placed on its byte lanes
//   rdata_o  read data, valid the cycle after the read was issued
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(2**ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
      if (be_i == 4'b0000) begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage load/store responder for the pipelined MIPS
// core. Stores complete in the request cycle; loads stall the pipeline for
// one cycle while the synchronous RAM returns data. Misaligned accesses are
// flagged and ignored.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/we/size/...    memory request from the M stage
//   stall                    freeze M and older stages
//   rdata                    extended load result (nonzero only in RD)
//   addr_err, err_addr       misaligned flag and last misaligned address
//
// state   | meaning
// ST_IDLE | evaluating the request on the inputs
// ST_RD   | RAM data available; held load completes, stall released
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] err_addr
);

  state_e      state_q, state_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [1:0]  lane;
  logic        aligned;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane    = req_addr[1:0];
  assign aligned = is_aligned(req_size, lane);

  always_comb begin
    wr_be   = 4'hF;
    wr_data = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    err_addr_d = err_addr_q;
    stall      = 1'b0;
    addr_err   = 1'b0;
    ram_en     = 1'b0;
    ram_be     = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!aligned) begin
            addr_err   = 1'b1;
            err_addr_d = req_addr;
          end else if (req_we) begin
            ram_en = 1'b1;
            ram_be = wr_be;
          end else begin
            ram_en  = 1'b1;
            stall   = 1'b1;
            state_d = ST_RD;
          end
        end
      end
      // The load is still on the inputs; leave unconditionally so the next
      // request is evaluated fresh in IDLE.
      ST_RD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Reset blocks RAM access so a store presented during reset is dropped.
  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en & ~rst),
    .be_i    (ram_be),
    .addr_i  (req_addr[ADDR_W+1:2]),
    .wdata_i (wr_data),
    .rdata_o (ram_rdata)
  );

  // Lane selection uses the held request, which is still the load in RD.
  assign byte_sel = ram_rdata[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    rdata = '0;
    if (state_q == ST_RD) begin
      case (req_size)
        SZ_BYTE: rdata = req_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        SZ_HALF: rdata = req_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        default: rdata = ram_rdata;
      endcase
    end
  end

  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rdata        (rdata),
    .addr_err     (addr_err),
    .err_addr     (err_addr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: plain byte array, 4 KiB image (addresses wrap at 4096).
  logic [7:0]  mdl [4096];
  logic [31:0] exp_rd_q  [$];
  logic [31:0] exp_err_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int b;
    logic [7:0]  v8;
    logic [15:0] v16;
    b = int'(a[11:0]);
    if (sz == 2'b00) begin
      v8 = mdl[b];
      return uns ? {24'b0, v8} : {{24{v8[7]}}, v8};
    end else if (sz == 2'b01) begin
      v16 = {mdl[b+1], mdl[b]};
      return uns ? {16'b0, v16} : {{16{v16[15]}}, v16};
    end
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  // Present one request and hold it until the pipeline would advance.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int b;
    int cycles;
    b = int'(a[11:0]);
    if (misaligned(sz, a)) begin
      exp_err_q.push_back(a);
    end else if (we) begin
      if (sz == 2'b00) begin
        mdl[b] = wd[7:0];
      end else if (sz == 2'b01) begin
        mdl[b] = wd[7:0]; mdl[b+1] = wd[15:8];
      end else begin
        mdl[b] = wd[7:0]; mdl[b+1] = wd[15:8]; mdl[b+2] = wd[23:16]; mdl[b+3] = wd[31:24];
      end
    end else begin
      exp_rd_q.push_back(mdl_load(sz, uns, a));
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    cycles = 0;
    forever begin
      #1;
      if (!stall) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      cycles++;
      if (cycles > 3) begin
        n_checks++; n_errors++;
        $display("FAIL stall_timeout: stall held %0d cycles, expected at most 1", cycles);
        break;
      end
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pairs each DUT response with the oldest queued expectation.
  initial begin
    logic        prev_stall;
    logic        err_pend;
    logic [31:0] err_exp;
    prev_stall = 1'b0;
    err_pend   = 1'b0;
    err_exp    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        err_pend   = 1'b0;
      end else begin
        if (err_pend) begin
          check("err_addr", err_addr, err_exp);
          err_pend = 1'b0;
        end
        if (prev_stall) check("stall_len", 32'(stall), 32'd0);
        if (prev_stall && !stall) begin
          if (exp_rd_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_response: rdata %08h with no load pending", rdata);
          end else begin
            check("load_rdata", rdata, exp_rd_q.pop_front());
          end
        end else begin
          check("rdata_idle", rdata, 32'd0);
        end
        if (addr_err) begin
          check("err_no_stall", 32'(stall), 32'd0);
          if (exp_err_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_addr_err: addr %08h got 1 expected 0", req_addr);
          end else begin
            err_exp  = exp_err_q.pop_front();
            err_pend = 1'b1;
          end
        end
        prev_stall = stall;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_addr_err", 32'(addr_err), 32'd0);
    check("reset_err_addr", err_addr, 32'd0);

    for (int w = 0; w < 128; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    idle(1);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h7, 32'h1234);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A55A5A);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'hFFFF_F041, 32'h0000_0077);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_1040, 32'h0);
    idle(2);

    // Reset while the load sits in RD: abandoned, nothing queued for it.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_rd_stall", 32'(stall), 32'd0);
    check("rst_rd_rdata", rdata, 32'd0);
    check("rst_rd_err_addr", err_addr, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    for (int i = 0; i < 400; i++) begin
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 511));
      sz = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    check("pending_loads", 32'(exp_rd_q.size()), 32'd0);
    check("pending_errs", 32'(exp_err_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core. Serves the memory-stage load/store requests issued by the datapath (address from `aluoutM`, store data from `writedataM`) and returns `readdataM`. Backed by an internal single-port synchronous-read RAM. Supports byte, halfword and word accesses with sign or zero extension. Stalls the pipeline for exactly one cycle per load and flags misaligned accesses.

## Interface
- `ADDR_W`, 10, word-address width; RAM holds 2^ADDR_W 32-bit words.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: memory op present in M stage (memtoregM | memwriteM).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word; 11 is reserved and treated as word.
- `req_unsigned` in 1: loads only; 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified (value in low bits).
- `stall` out 1: freeze M stage and all older stages.
- `rdata` out 32: extended load result (readdataM).
- `addr_err` out 1: misaligned access this cycle.
- `err_addr` out 32: address of most recent misaligned access.

## Operation
- Byte order is little-endian. Lane k holds bits [8k+7:8k], and k = `req_addr[1:0]`.
- Word index is `req_addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
- Misaligned access:
  - halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No RAM read or write, no stall.
  - `addr_err`=1 combinationally in that cycle.
  - `err_addr` ← `req_addr` at the edge.
- Store (aligned):
  - Completes in the request cycle with no stall.
  - RAM written at the edge with byte enables:
    - byte: 1 lane, data replicated on all lanes.
    - half: lanes {2h+1, 2h}, where h = `addr[1]`.
    - word: all 4 lanes.
- Load FSM, states IDLE and RD:
  - IDLE, aligned load: issue RAM read, `stall`=1, go to RD.
  - RD: the request is still held by the stall. `stall`=0. `rdata` = selected lane(s) of the RAM output, extended per `req_size`/`req_unsigned`. Go to IDLE.
  - The transition out of RD is unconditional. The next request is evaluated in IDLE the following cycle, so back-to-back loads each cost one stall cycle.
- `rdata` = 0 whenever state ≠ RD.
- `req_valid`=0: no RAM access, `stall`=0, `addr_err`=0.

## Timing
- Reset values:
  - state IDLE; `stall`=0, `rdata`=0, `addr_err`=0, `err_addr`=0.
  - RAM contents are not reset.
- Load latency: request in cycle N, data valid in N+1. The pipeline advances at the end of N+1 (1 stall cycle).
- Store latency: 0 stall cycles; write visible to a read issued in the next cycle.
- Store in N followed by a load of the same word in N+1 returns the new data.
- `rst` asserted while in RD: next state IDLE, `stall`=0, `rdata`=0, and the load is abandoned. No RAM write occurs during a reset cycle.
- `stall` and `addr_err` are combinational from state and request inputs. `rdata` is combinational from the RAM output register.

## Structure
- Shared package `mem_pkg`:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`).
  - FSM state enum (`ST_IDLE`, `ST_RD`).
- Sub-module `dmem_ram`: single-port RAM, 2^ADDR_W×32, 4-bit byte write enable, registered read data. Infers block RAM.
- Top level holds the FSM, lane/enable generation, extension logic and `err_addr` register.

## Test plan
- Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10. Response: `stall` high 1 cycle, `rdata`=0xDEADBEEF.
- Byte extension: after the word above, lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lb @0x10 → 0xFFFFFFEF.
- Halfword: sh 0x8001 @0x22, then lhu @0x22 → 0x00008001 and lh @0x22 → 0xFFFF8001. Bytes @0x20/0x21 are unchanged.
- Misaligned: lw @0x102 → `addr_err`=1, `stall`=0, next cycle `err_addr`=0x00000102, and the RAM word @0x100 is unchanged. sh @0x7 → `addr_err`=1.
- Back-to-back loads: lw @0x0, lw @0x4 on consecutive issue. Each load stalls exactly 1 cycle and returns the correct data. Store in N then lw of the same address in N+1 returns the new data.
- Reset mid-load: assert `rst` during RD. Next cycle state IDLE, `stall`=0, `rdata`=0, `err_addr`=0. A fresh lw afterwards behaves normally.
